// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types for the PLL lock to reset-release sequencer.
// Holds the FSM state encoding, the loss-counter width and a small max helper.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        SDRAM_WAIT,
        CORE_WAIT,
        RUN
    } pll_rst_state_t;

    localparam int LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Generic multi-flop synchroniser for a single asynchronous flag.
// Synchronous active-high clear forces every stage to 0.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the PLL lock flag into ordered SDRAM / core reset releases and a ready flag.
// Optional lock-loss counter enabled by defining PLL_RESET_LOSS_COUNT_EN.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SDRAM_WAIT_CYCLES  = 10000,
    parameter int CORE_DELAY_CYCLES  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pll_locked,
    output logic                  sdram_reset,
    output logic                  core_reset,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_losses,
    output pll_rst_state_t        dbg_state
);

    localparam int CNT_W = $clog2(max3(LOCK_STABLE_CYCLES, SDRAM_WAIT_CYCLES, CORE_DELAY_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SDRAM_TERM  = CNT_W'(SDRAM_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_TERM   = CNT_W'(CORE_DELAY_CYCLES - 1);

    pll_rst_state_t   r_state;
    pll_rst_state_t   w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_locked_s;
    logic             w_lock_lost;
    logic             r_sdram_reset;
    logic             r_core_reset;
    logic             r_ready;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clock),
        .clr (reset),
        .d   (pll_locked),
        .q   (w_locked_s)
    );

    always_comb begin
        w_next_state = r_state;
        w_lock_lost  = 1'b0;
        case (r_state)
            WAIT_LOCK:  if (w_locked_s) w_next_state = STABLE;
            STABLE:     if (r_cnt == STABLE_TERM) w_next_state = SDRAM_WAIT;
            SDRAM_WAIT: if (r_cnt == SDRAM_TERM) w_next_state = CORE_WAIT;
            CORE_WAIT:  if (r_cnt == CORE_TERM) w_next_state = RUN;
            RUN:        w_next_state = RUN;
            default:    w_next_state = WAIT_LOCK;
        endcase
        // Lock loss overrides any terminal-count advance in the same cycle.
        if (r_state != WAIT_LOCK && !w_locked_s) begin
            w_next_state = WAIT_LOCK;
            w_lock_lost  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= WAIT_LOCK;
            r_cnt         <= '0;
            r_sdram_reset <= 1'b1;
            r_core_reset  <= 1'b1;
            r_ready       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state == STABLE || r_state == SDRAM_WAIT || r_state == CORE_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Outputs decode the next state so they change on the same edge as r_state.
            r_sdram_reset <= (w_next_state == WAIT_LOCK) || (w_next_state == STABLE);
            r_core_reset  <= (w_next_state == WAIT_LOCK) || (w_next_state == STABLE) ||
                             (w_next_state == SDRAM_WAIT);
            r_ready       <= (w_next_state == RUN);
        end
    end

`ifdef PLL_RESET_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] r_lock_losses;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lock_losses <= '0;
        end else if (w_lock_lost && r_lock_losses != '1) begin
            r_lock_losses <= r_lock_losses + 1'b1;
        end
    end

    assign lock_losses = r_lock_losses;
`else
    assign lock_losses = '0;
`endif

    assign sdram_reset = r_sdram_reset;
    assign core_reset  = r_core_reset;
    assign ready       = r_ready;
    assign dbg_state   = r_state;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumes the PLL `locked` flag produced by the ULX3S clock generator and turns it into ordered, glitch-free reset releases for the SDRAM controller and the RISC-V core. It synchronises `locked` into the system clock domain and requires a stable lock window. It then releases SDRAM reset, waits out the SDRAM power-up interval, and only then releases the core. On any loss of lock it re-asserts every reset and restarts the sequence.

## Interface

Parameters:
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchroniser chain (≥2)
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before releasing SDRAM (≥1)
- `SDRAM_WAIT_CYCLES`, 10000: cycles between SDRAM reset release and core reset release (100 µs at 100 MHz) (≥1)
- `CORE_DELAY_CYCLES`, 16: cycles between core reset release and `ready` (≥1)

Ports:
- `clock` in 1: system clock, the 100 MHz PLL output
- `reset` in 1: synchronous, active-high
- `pll_locked` in 1: PLL lock flag, asynchronous to `clock`
- `sdram_reset` out 1: active-high reset to the SDRAM controller
- `core_reset` out 1: active-high reset to the CPU and peripherals
- `ready` out 1: sequence complete, system running
- `lock_losses` out 8: saturating count of lock-loss events (see Configuration)

## Operation

- Synchroniser: `pll_locked` passes through `SYNC_STAGES` flops to give `locked_s`. There is no other use of raw `pll_locked`.
- A single counter, `CNT_W = $clog2(max(LOCK_STABLE_CYCLES, SDRAM_WAIT_CYCLES, CORE_DELAY_CYCLES)) + 1` bits wide, is cleared on every state entry.
- FSM states and transitions:
  - WAIT_LOCK: go to STABLE when `locked_s` = 1.
  - STABLE: count up each cycle. When the count reaches `LOCK_STABLE_CYCLES-1`, go to SDRAM_WAIT.
  - SDRAM_WAIT: count up. When the count reaches `SDRAM_WAIT_CYCLES-1`, go to CORE_WAIT.
  - CORE_WAIT: count up. When the count reaches `CORE_DELAY_CYCLES-1`, go to RUN.
  - RUN: terminal while `locked_s` = 1.
- Lock loss: `locked_s` = 0 in any state other than WAIT_LOCK forces WAIT_LOCK on the next edge. This takes priority over every counter-terminal transition in the same cycle.
- Output decode:
  - `sdram_reset` = 1 in WAIT_LOCK and STABLE.
  - `core_reset` = 1 in WAIT_LOCK, STABLE and SDRAM_WAIT.
  - `ready` = 1 only in RUN.
- All outputs are flops updated on the same edge as the state register, so there is no combinational path from `pll_locked` to any output.
- `reset` mid-sequence:
  - Next edge: state WAIT_LOCK, counter 0, outputs at reset values.
  - The synchroniser flops clear to 0.
  - `lock_losses` clears to 0.

## Timing

- Reset values: `sdram_reset`=1, `core_reset`=1, `ready`=0, `lock_losses`=0, state WAIT_LOCK.
- If `pll_locked` is high before edge 0, `locked_s` is high after edge `SYNC_STAGES-1`, and STABLE is entered at edge `SYNC_STAGES`.
- Release points, counting edges from edge 0:
  - `sdram_reset` falls at edge `SYNC_STAGES+LOCK_STABLE_CYCLES`.
  - `core_reset` falls `SDRAM_WAIT_CYCLES` edges later.
  - `ready` rises `CORE_DELAY_CYCLES` edges after that.
- Lock-loss response: a drop in `pll_locked` reaches `locked_s` after `SYNC_STAGES` edges. All three reset-side outputs return to their reset values on the following edge.
- Lock pulses shorter than `LOCK_STABLE_CYCLES` never release `sdram_reset`.

## Configuration

- Macro: `PLL_RESET_LOSS_COUNT_EN`.
- Defined:
  - `lock_losses` increments by 1 on each transition into WAIT_LOCK caused by lock loss. Transitions caused by `reset` do not count.
  - The count saturates at 255.
- Undefined: `lock_losses` is tied to 8'd0 and no counter flops are instantiated. The port exists in both builds.

## Structure

- Shared package `pll_reset_pkg` holds:
  - the state enum `pll_rst_state_t` {WAIT_LOCK, STABLE, SDRAM_WAIT, CORE_WAIT, RUN};
  - the `LOSS_CNT_W` = 8 constant.
- One sub-module: `sync_bit`, a parameterised `SYNC_STAGES` flop chain with synchronous active-high clear. It is reused elsewhere for other asynchronous flags.
- FSM, counter and optional loss counter live in the top module.

## Test plan

Bench parameters: `SYNC_STAGES`=2, `LOCK_STABLE_CYCLES`=8, `SDRAM_WAIT_CYCLES`=20, `CORE_DELAY_CYCLES`=4.

- Reset with `pll_locked`=0 for 50 cycles -> `sdram_reset`=1, `core_reset`=1, `ready`=0, `lock_losses`=0 throughout.
- `pll_locked` held high from edge 0 -> `sdram_reset` falls at edge 10, `core_reset` falls at edge 30, `ready` rises at edge 34.
- `pll_locked` high for 5 cycles then low -> `sdram_reset` never falls. `lock_losses`=1 with the macro defined, 0 without.
- In RUN, drop `pll_locked` for 1 cycle -> all resets re-asserted and `ready`=0 within 3 edges. Full sequence repeats: `ready` rises 34 edges after lock returns. `lock_losses` increments by 1.
- Lock loss on the same cycle SDRAM_WAIT reaches its terminal count -> state goes to WAIT_LOCK, not CORE_WAIT, and `core_reset` stays 1.
- 300 lock-loss events with the macro defined -> `lock_losses` saturates at 255. Assert `reset` in RUN -> outputs reach reset values next edge and `lock_losses`=0.
